// File: rtl/adder_tree_pkg.sv
// Shared sizing helpers for the signed pipelined adder tree.
// Optional feature macro: ADDER_TREE_ACCUM_EN (adds accumulator headroom to the output width).
package adder_tree_pkg;

`ifdef ADDER_TREE_ACCUM_EN
  localparam bit AccumEn = 1'b1;
`else
  localparam bit AccumEn = 1'b0;
`endif

  // Width of the registers produced by tree level 'level' is width + level + 1;
  // this returns the width of the operands entering that level.
  function automatic int unsigned stage_w(input int unsigned width, input int unsigned level);
    return width + level;
  endfunction

  function automatic int unsigned out_w(input int unsigned width, input int unsigned n_inputs,
                                        input int unsigned acc_bits);
    return width + $clog2(n_inputs) + (AccumEn ? acc_bits : 0);
  endfunction

endpackage

// File: rtl/adder_tree_signed_pipelined_if.sv
// Operand/result handshake bundle for adder_tree_signed_pipelined.
//   in/in_valid/in_ready : operand beat (in_last only with ADDER_TREE_ACCUM_EN)
//   out/out_valid/out_ready : result
// Modports: master = producer/consumer side, slave = adder tree side.
interface adder_tree_signed_pipelined_if
  import adder_tree_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned N_INPUTS = 16,
  parameter int unsigned ACC_BITS = 8,
  parameter int unsigned OUT_W    = out_w(WIDTH, N_INPUTS, ACC_BITS)
);
  logic signed [N_INPUTS-1:0][WIDTH-1:0] in;
  logic                                  in_valid;
  logic                                  in_ready;
`ifdef ADDER_TREE_ACCUM_EN
  logic                                  in_last;
`endif
  logic signed [OUT_W-1:0]               out;
  logic                                  out_valid;
  logic                                  out_ready;

`ifdef ADDER_TREE_ACCUM_EN
  modport master (output in, in_valid, in_last, out_ready, input in_ready, out, out_valid);
  modport slave  (input in, in_valid, in_last, out_ready, output in_ready, out, out_valid);
`else
  modport master (output in, in_valid, out_ready, input in_ready, out, out_valid);
  modport slave  (input in, in_valid, out_ready, output in_ready, out, out_valid);
`endif

endinterface

// File: rtl/adder_tree_level.sv
// One registered pair-reduction level of the adder tree: adds adjacent signed
// operands into results one bit wider and registers them with a valid bit.
// Ports: clk, rst_n (async active-low), en_i (advance), data_i/valid_i in,
// data_o/valid_o out; last_i/last_o only with ADDER_TREE_ACCUM_EN.
module adder_tree_level #(
  parameter int unsigned N_ELEMS = 2,
  parameter int unsigned IN_W    = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en_i,
  input  logic [N_ELEMS-1:0][IN_W-1:0]     data_i,
  input  logic                             valid_i,
`ifdef ADDER_TREE_ACCUM_EN
  input  logic                             last_i,
  output logic                             last_o,
`endif
  output logic [N_ELEMS/2-1:0][IN_W:0]     data_o,
  output logic                             valid_o
);
  localparam int unsigned NOut = N_ELEMS / 2;

  logic [NOut-1:0][IN_W:0] sum;
  logic [NOut-1:0][IN_W:0] data_q;
  logic                    valid_q;

  always_comb begin
    sum = '0;
    for (int j = 0; j < NOut; j++) begin
      sum[j] = (IN_W + 1)'($signed(data_i[2*j])) + (IN_W + 1)'($signed(data_i[2*j+1]));
    end
  end

  // Bubbles advance with the data; only a stall (en_i low) freezes the level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (en_i) begin
      data_q  <= sum;
      valid_q <= valid_i;
    end
  end

`ifdef ADDER_TREE_ACCUM_EN
  logic last_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_q <= 1'b0;
    else if (en_i) last_q <= last_i;
  end
  assign last_o = last_q;
`endif

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/adder_tree_signed_pipelined.sv
// Pipelined signed adder tree: sums N_INPUTS WIDTH-bit operands per beat with
// $clog2(N_INPUTS) register levels and valid/ready backpressure.
// Ports: clk, rst_n (async active-low), bus (adder_tree_signed_pipelined_if.slave).
// Optional macro ADDER_TREE_ACCUM_EN: tree results are accumulated across a
// group and only the group total (marked by in_last) is presented on out.
module adder_tree_signed_pipelined
  import adder_tree_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned N_INPUTS = 16,
  parameter int unsigned ACC_BITS = 8
) (
  input logic                          clk,
  input logic                          rst_n,
  adder_tree_signed_pipelined_if.slave bus
);
  localparam int unsigned LEVELS = $clog2(N_INPUTS);
  localparam int unsigned TREE_W = stage_w(WIDTH, LEVELS);
  localparam int unsigned OUT_W  = out_w(WIDTH, N_INPUTS, ACC_BITS);

  logic                     stall;
  logic                     en;
  logic signed [TREE_W-1:0] tree_sum;
  logic                     tree_valid;
`ifdef ADDER_TREE_ACCUM_EN
  logic                     tree_last;
`endif

  // Only a result waiting at the output can stall; the whole pipe freezes together.
  assign stall        = bus.out_valid && !bus.out_ready;
  assign en           = !stall;
  assign bus.in_ready = en;

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int unsigned NE = N_INPUTS >> l;
    localparam int unsigned IW = stage_w(WIDTH, l);

    logic [NE-1:0][IW-1:0]   din;
    logic [NE/2-1:0][IW:0]   dout;
    logic                    vin;
    logic                    vout;
`ifdef ADDER_TREE_ACCUM_EN
    logic                    lin;
    logic                    lout;
`endif

    if (l == 0) begin : g_first
      assign din = bus.in;
      assign vin = bus.in_valid;
`ifdef ADDER_TREE_ACCUM_EN
      assign lin = bus.in_last;
`endif
    end else begin : g_next
      assign din = g_lvl[l-1].dout;
      assign vin = g_lvl[l-1].vout;
`ifdef ADDER_TREE_ACCUM_EN
      assign lin = g_lvl[l-1].lout;
`endif
    end

    adder_tree_level #(
      .N_ELEMS (NE),
      .IN_W    (IW)
    ) u_level (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (en),
      .data_i  (din),
      .valid_i (vin),
`ifdef ADDER_TREE_ACCUM_EN
      .last_i  (lin),
      .last_o  (lout),
`endif
      .data_o  (dout),
      .valid_o (vout)
    );
  end

  assign tree_sum   = g_lvl[LEVELS-1].dout[0];
  assign tree_valid = g_lvl[LEVELS-1].vout;

`ifdef ADDER_TREE_ACCUM_EN
  logic signed [OUT_W-1:0] sum_ext;
  logic signed [OUT_W-1:0] acc_q;
  logic signed [OUT_W-1:0] acc_d;

  assign tree_last = g_lvl[LEVELS-1].lout;
  assign sum_ext   = OUT_W'(tree_sum);

  // Partial sums fold in as they pass the last level; the group total clears
  // the accumulator as it is handed off downstream. Wraps modulo 2^OUT_W.
  always_comb begin
    acc_d = acc_q;
    if (tree_valid && en) begin
      acc_d = tree_last ? '0 : acc_q + sum_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign bus.out       = acc_q + sum_ext;
  assign bus.out_valid = tree_valid && tree_last;
`else
  assign bus.out       = OUT_W'(tree_sum);
  assign bus.out_valid = tree_valid;
`endif

endmodule

// File: doc/adder_tree_signed_pipelined.md
ADDER_TREE_SIGNED_PIPELINED -- requirements
Module: adder_tree_signed_pipelined

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, meaning the signed two's-complement width of each input operand.
REQ-002 The module SHALL have parameter N_INPUTS, default 16, meaning the number of operands summed per beat; it SHALL be a power of two and at least 2.
REQ-003 The module SHALL have parameter ACC_BITS, default 8, meaning the extra accumulator headroom; it is used only when ADDER_TREE_ACCUM_EN is defined.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The module SHALL have port in, input, N_INPUTS x WIDTH packed signed: the operands, with element i at in[i].
REQ-007 The module SHALL have port in_valid, input, 1 bit: asserted when in holds a beat.
REQ-008 The module SHALL have port in_ready, output, 1 bit: asserted when the block accepts a beat this cycle.
REQ-009 The module SHALL have port in_last, input, 1 bit: marks the final beat of a group; it exists only with ADDER_TREE_ACCUM_EN.
REQ-010 The module SHALL have port out, output, OUT_W bits signed: the sum, where OUT_W = WIDTH + $clog2(N_INPUTS), plus ACC_BITS with ADDER_TREE_ACCUM_EN.
REQ-011 The module SHALL have port out_valid, output, 1 bit: asserted when out holds a result.
REQ-012 The module SHALL have port out_ready, input, 1 bit: asserted when the downstream consumer accepts out.

Function
REQ-013 The tree SHALL have LEVELS = $clog2(N_INPUTS) pipeline stages, each adding adjacent pairs of the previous stage into a register one bit wider, with a valid bit per stage.
REQ-014 All additions SHALL sign-extend their operands; no overflow is possible within OUT_W, so the sum is exact.
REQ-015 A beat is accepted when in_valid && in_ready; absent stalls, its sum SHALL appear on out with out_valid high exactly LEVELS cycles later (16 inputs: 4 cycles).
REQ-016 Stall condition: stall = out_valid && !out_ready; while stalled, every stage register and valid bit SHALL hold its value, and in_ready = !stall (combinational).
REQ-017 When not stalled, all stages SHALL advance every cycle; bubbles (invalid stages) advance as well and are not compacted.
REQ-018 A transfer on out occurs when out_valid && out_ready; out SHALL be stable while out_valid is high and out_ready is low.
REQ-019 Full throughput SHALL be sustained: one beat accepted per cycle while out_ready stays high.
REQ-020 A beat presented with in_valid high while in_ready is low SHALL NOT be captured, and the source SHALL hold it.

Reset
REQ-021 While rst_n is low, all stage valid bits, out_valid, and the accumulator SHALL be 0, and out SHALL be 0, asynchronously.
REQ-022 Reset asserted mid-stream SHALL discard every in-flight beat; the first beat accepted after release SHALL emerge LEVELS cycles after its acceptance.
REQ-023 in_ready SHALL be 1 during and after reset, because out_valid is 0.

Configuration
REQ-024 The macro ADDER_TREE_ACCUM_EN SHALL control accumulation.
REQ-025 Without ADDER_TREE_ACCUM_EN, every accepted beat SHALL produce one output, and in_last SHALL be absent.
REQ-026 With ADDER_TREE_ACCUM_EN, in_last SHALL travel with the beat through the stages; non-last tree results SHALL be added into an OUT_W-bit signed accumulator without asserting out_valid.
REQ-027 With ADDER_TREE_ACCUM_EN, a last beat SHALL produce out = accumulator + tree sum with out_valid high.
REQ-028 With ADDER_TREE_ACCUM_EN, the accumulator SHALL clear on the same edge that the last beat is registered.
REQ-029 With ADDER_TREE_ACCUM_EN, accumulator overflow SHALL wrap modulo 2^OUT_W.
REQ-030 With ADDER_TREE_ACCUM_EN, the accumulator SHALL hold during a stall.

Structure
REQ-031 Package adder_tree_pkg SHALL provide the stage-width function (WIDTH + level) and the OUT_W calculation.
REQ-032 Sub-module adder_tree_level SHALL implement one registered pair-reduction stage (parameters: element count and input width; ports: data and valid in, data and valid out, enable) and SHALL be instantiated LEVELS times by a generate loop.

Verification (WIDTH=4, N_INPUTS=16)
REQ-033 in[i]=i for i=0..15, a single beat -> out=-8, out_valid high exactly 4 cycles after acceptance.
REQ-034 All in[i]=4'b1000 -> out=-128; all in[i]=7 -> out=112; all in[i]=0 -> out=0.
REQ-035 Three back-to-back beats (sums -8, -128, 112), out_ready held low for 2 cycles when the first result appears -> in_ready low during those cycles, results delivered in order with no loss or duplication.
REQ-036 rst_n pulsed low while 2 beats are in flight -> out_valid stays 0, no stale result emerges; a new beat summing 0 appears 4 cycles after acceptance.
REQ-037 With ADDER_TREE_ACCUM_EN: three beats of in[i]=i with in_last on the third -> a single output of -24 with out_valid high for one transfer; the next group, a single beat of all 8 with in_last, -> -128, confirming the accumulator cleared.
